// File: rtl/cursor_roi_ctrl_if.sv
// Signal bundle between cursor_roi_ctrl and its environment:
// buttons, switches and frame pulse inward; cursor position and committed ROI outward.
interface cursor_roi_ctrl_if;
  localparam int unsigned CW = 13;

  logic [3:0]    KEY;
  logic [9:0]    SW;
  logic          frame_start;
  logic [CW-1:0] cur_row;
  logic [CW-1:0] cur_col;
  logic [CW-1:0] roi_min_row;
  logic [CW-1:0] roi_max_row;
  logic [CW-1:0] roi_min_col;
  logic [CW-1:0] roi_max_col;
  logic          roi_valid;
  logic [1:0]    roi_state;

  modport master (
    output KEY, SW, frame_start,
    input  cur_row, cur_col, roi_min_row, roi_max_row,
           roi_min_col, roi_max_col, roi_valid, roi_state
  );

  modport slave (
    input  KEY, SW, frame_start,
    output cur_row, cur_col, roi_min_row, roi_max_row,
           roi_min_col, roi_max_col, roi_valid, roi_state
  );
endinterface

// File: rtl/cursor_roi_ctrl.sv
// Cursor stepping, two-corner ROI lock FSM and frame-synchronous ROI publication.
// Optional macro CURSOR_ACCEL_EN doubles the step after a run of same-direction ticks.
module cursor_roi_ctrl #(
  parameter int unsigned H_LIMIT     = 640,
  parameter int unsigned V_LIMIT     = 480,
  parameter int unsigned VELOCITY    = 8,
  parameter int unsigned TICK_DIV    = 2097152,
  parameter int unsigned ACCEL_TICKS = 8
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  cursor_roi_ctrl_if.slave   bus
);
  localparam int unsigned CW = 13;
  localparam int unsigned SW_W = 14;
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]          ROW_CTR   = CW'(V_LIMIT / 2);
  localparam logic [CW-1:0]          COL_CTR   = CW'(H_LIMIT / 2);
  localparam logic [TW-1:0]          TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic signed [SW_W-1:0] H_S       = SW_W'(H_LIMIT);
  localparam logic signed [SW_W-1:0] V_S       = SW_W'(V_LIMIT);

  typedef enum logic [1:0] {S_OFF = 2'd0, S_READY = 2'd1, S_LOCK1 = 2'd2, S_LOCK2 = 2'd3} roi_state_e;
  typedef enum logic [1:0] {DIR_LEFT = 2'd0, DIR_UP = 2'd1, DIR_DOWN = 2'd2, DIR_RIGHT = 2'd3} dir_e;

  typedef struct packed {
    logic [CW-1:0] min_row;
    logic [CW-1:0] max_row;
    logic [CW-1:0] min_col;
    logic [CW-1:0] max_col;
    logic          valid;
  } roi_t;

  // Input synchronisers; sw bits packed as {lock, draw, enable}
  logic [3:0] key_s1, key_s2;
  logic [2:0] sw_s1, sw_s2;
  logic       lock_s3;
  logic       unused_sw;

  assign unused_sw = ^{bus.SW[9:7], bus.SW[4:1]};

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_s1  <= '1;
      key_s2  <= '1;
      sw_s1   <= '0;
      sw_s2   <= '0;
      lock_s3 <= 1'b0;
    end else begin
      key_s1  <= bus.KEY;
      key_s2  <= key_s1;
      sw_s1   <= {bus.SW[6], bus.SW[5], bus.SW[0]};
      sw_s2   <= sw_s1;
      lock_s3 <= sw_s2[2];
    end
  end

  logic en_c, draw_c, lock_c, lock_rise_c, lock_fall_c;
  assign en_c        = sw_s2[0];
  assign draw_c      = sw_s2[1];
  assign lock_c      = sw_s2[2];
  assign lock_rise_c = lock_c & ~lock_s3;
  assign lock_fall_c = ~lock_c & lock_s3;

  // Movement tick
  logic [TW-1:0] tick_cnt;
  logic          tick_c;
  assign tick_c = (tick_cnt == TICK_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset || tick_c) tick_cnt <= '0;
    else                 tick_cnt <= tick_cnt + TW'(1);
  end

  logic [3:0] pressed_c;
  logic       any_key_c;
  dir_e       dir_c;
  assign pressed_c = ~key_s2;
  assign any_key_c = |pressed_c;

  always_comb begin
    dir_c = DIR_RIGHT;
    if      (pressed_c[3]) dir_c = DIR_LEFT;
    else if (pressed_c[2]) dir_c = DIR_UP;
    else if (pressed_c[1]) dir_c = DIR_DOWN;
  end

  logic signed [SW_W-1:0] step_c;

`ifdef CURSOR_ACCEL_EN
  localparam int unsigned RW = $clog2(ACCEL_TICKS + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(ACCEL_TICKS);

  logic [RW-1:0] run_q, run_d;
  dir_e          pdir_q;
  logic          pdir_vld_q;

  // Run length saturates at ACCEL_TICKS; step uses the count including this tick
  always_comb begin
    run_d = '0;
    if (pdir_vld_q && (pdir_q == dir_c))
      run_d = (run_q == RUN_MAX) ? run_q : run_q + RW'(1);
  end

  assign step_c = (run_d >= RUN_MAX) ? SW_W'(2 * VELOCITY) : SW_W'(VELOCITY);

  always_ff @(posedge CLOCK_50) begin
    if (reset || !en_c || !any_key_c) begin
      run_q      <= '0;
      pdir_q     <= DIR_LEFT;
      pdir_vld_q <= 1'b0;
    end else if (tick_c) begin
      run_q      <= run_d;
      pdir_q     <= dir_c;
      pdir_vld_q <= 1'b1;
    end
  end
`else
  assign step_c = SW_W'(VELOCITY);
`endif

  // Cursor stepping with single wrap at screen edges
  logic [CW-1:0]          cur_row_q, cur_col_q, row_nxt_c, col_nxt_c;
  logic signed [SW_W-1:0] row_s_c, col_s_c, row_mv_c, col_mv_c;
  assign row_s_c = $signed({1'b0, cur_row_q});
  assign col_s_c = $signed({1'b0, cur_col_q});

  always_comb begin
    row_mv_c = row_s_c;
    col_mv_c = col_s_c;
    unique case (dir_c)
      DIR_LEFT: begin
        col_mv_c = col_s_c - step_c;
        if (col_mv_c < 14'sd0) col_mv_c = col_mv_c + H_S;
      end
      DIR_RIGHT: begin
        col_mv_c = col_s_c + step_c;
        if (col_mv_c >= H_S) col_mv_c = col_mv_c - H_S;
      end
      DIR_UP: begin
        row_mv_c = row_s_c - step_c;
        if (row_mv_c < 14'sd0) row_mv_c = row_mv_c + V_S;
      end
      DIR_DOWN: begin
        row_mv_c = row_s_c + step_c;
        if (row_mv_c >= V_S) row_mv_c = row_mv_c - V_S;
      end
    endcase
    row_nxt_c = CW'(row_mv_c);
    col_nxt_c = CW'(col_mv_c);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset || !en_c) begin
      cur_row_q <= ROW_CTR;
      cur_col_q <= COL_CTR;
    end else if (tick_c && any_key_c) begin
      cur_row_q <= row_nxt_c;
      cur_col_q <= col_nxt_c;
    end
  end

  // Second corner is the current cursor; it feeds the pending bounds directly
  logic [CW-1:0] p1_row_q, p1_col_q, p1_row_d, p1_col_d;
  logic [CW-1:0] lo_row_c, hi_row_c, lo_col_c, hi_col_c;
  logic          sel_ok_c;
  assign lo_row_c = (p1_row_q < cur_row_q) ? p1_row_q : cur_row_q;
  assign hi_row_c = (p1_row_q < cur_row_q) ? cur_row_q : p1_row_q;
  assign lo_col_c = (p1_col_q < cur_col_q) ? p1_col_q : cur_col_q;
  assign hi_col_c = (p1_col_q < cur_col_q) ? cur_col_q : p1_col_q;
  assign sel_ok_c = (lo_row_c < hi_row_c) && (lo_col_c < hi_col_c);

  roi_state_e state_q, state_d;
  roi_t       pend_q, pend_d, roi_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= S_OFF;
      p1_row_q <= '0;
      p1_col_q <= '0;
      pend_q   <= '0;
    end else begin
      state_q  <= state_d;
      p1_row_q <= p1_row_d;
      p1_col_q <= p1_col_d;
      pend_q   <= pend_d;
    end
  end

  // Lock FSM; a degenerate selection leaves the pending ROI fully cleared
  always_comb begin
    state_d  = state_q;
    p1_row_d = p1_row_q;
    p1_col_d = p1_col_q;
    pend_d   = pend_q;
    if (!en_c || !draw_c) begin
      state_d = S_OFF;
      pend_d  = '0;
    end else begin
      unique case (state_q)
        S_OFF:   state_d = S_READY;
        S_READY: if (lock_c) begin
          state_d  = S_LOCK1;
          p1_row_d = cur_row_q;
          p1_col_d = cur_col_q;
        end
        S_LOCK1: if (lock_fall_c) begin
          state_d = S_LOCK2;
          pend_d  = sel_ok_c ? '{lo_row_c, hi_row_c, lo_col_c, hi_col_c, 1'b1} : '0;
        end
        S_LOCK2: if (lock_rise_c) begin
          state_d  = S_LOCK1;
          p1_row_d = cur_row_q;
          p1_col_d = cur_col_q;
        end
      endcase
    end
  end

  // Published ROI changes only on frame_start
  always_ff @(posedge CLOCK_50) begin
    if (reset)                roi_q <= '0;
    else if (bus.frame_start) roi_q <= pend_q;
  end

  assign bus.cur_row     = cur_row_q;
  assign bus.cur_col     = cur_col_q;
  assign bus.roi_min_row = roi_q.min_row;
  assign bus.roi_max_row = roi_q.max_row;
  assign bus.roi_min_col = roi_q.min_col;
  assign bus.roi_max_col = roi_q.max_col;
  assign bus.roi_valid   = roi_q.valid;
  assign bus.roi_state   = state_q;
endmodule

// File: tb/tb_cursor_roi_ctrl.sv
// Bench for cursor_roi_ctrl: directed scenarios plus random stimulus against a cycle-level reference model.
module tb_cursor_roi_ctrl;
  localparam int H   = 640;
  localparam int V   = 480;
  localparam int VEL = 8;
  localparam int TD  = 4;
`ifdef CURSOR_ACCEL_EN
  localparam int ACC = 2;
`else
  localparam int ACC = 8;
`endif

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  cursor_roi_ctrl_if bus();

  cursor_roi_ctrl #(.H_LIMIT(H), .V_LIMIT(V), .VELOCITY(VEL), .TICK_DIV(TD), .ACCEL_TICKS(ACC)) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .bus(bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: positions, FSM, pending/published ROI {min_row,max_row,min_col,max_col,valid}
  int m_row, m_col, m_cnt, m_st, m_p1r, m_p1c, m_run, m_pdir, m_pvld, moves;
  int pd[5];
  int ro[5];
  logic [3:0] mk1, mk2;
  logic [2:0] ms1, ms2;
  logic       ml3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_row = V / 2; m_col = H / 2; m_cnt = 0; m_st = 0; m_p1r = 0; m_p1c = 0;
    m_run = 0; m_pdir = 0; m_pvld = 0;
    pd = '{0, 0, 0, 0, 0};
    ro = '{0, 0, 0, 0, 0};
    mk1 = '1; mk2 = '1; ms1 = '0; ms2 = '0; ml3 = 1'b0;
  endtask

  task automatic model_edge();
    int nr, nc, nst, np1r, np1c, dir, stp, lr, hr, lc, hc;
    int npd[5];
    logic [3:0] pr;
    bit tick, en, dr, lk;
    if (reset) model_reset();
    else begin
      pr = ~mk2; en = ms2[0]; dr = ms2[1]; lk = ms2[2];
      tick = (m_cnt == TD - 1);
      nr = m_row; nc = m_col;
      if (!en) begin
        nr = V / 2; nc = H / 2; m_run = 0; m_pvld = 0;
      end else if (tick && pr != 0) begin
        dir = pr[3] ? 0 : pr[2] ? 1 : pr[1] ? 2 : 3;
        stp = VEL;
`ifdef CURSOR_ACCEL_EN
        if (m_pvld != 0 && dir == m_pdir) m_run = (m_run + 1 > ACC) ? ACC : m_run + 1;
        else m_run = 0;
        if (m_run >= ACC) stp = 2 * VEL;
        m_pdir = dir; m_pvld = 1;
`endif
        case (dir)
          0: nc = ((m_col - stp) % H + H) % H;
          1: nr = ((m_row - stp) % V + V) % V;
          2: nr = (m_row + stp) % V;
          default: nc = (m_col + stp) % H;
        endcase
        moves++;
      end else if (pr == 0) begin
        m_run = 0; m_pvld = 0;
      end
      nst = m_st; np1r = m_p1r; np1c = m_p1c; npd = pd;
      if (!en || !dr) begin
        nst = 0; npd = '{0, 0, 0, 0, 0};
      end else begin
        case (m_st)
          0: nst = 1;
          1: if (lk) begin nst = 2; np1r = m_row; np1c = m_col; end
          2: if (!lk && ml3) begin
               nst = 3;
               lr = (m_p1r < m_row) ? m_p1r : m_row; hr = (m_p1r < m_row) ? m_row : m_p1r;
               lc = (m_p1c < m_col) ? m_p1c : m_col; hc = (m_p1c < m_col) ? m_col : m_p1c;
               if (lr < hr && lc < hc) npd = '{lr, hr, lc, hc, 1};
               else npd = '{0, 0, 0, 0, 0};
             end
          default: if (lk && !ml3) begin nst = 2; np1r = m_row; np1c = m_col; end
        endcase
      end
      if (bus.frame_start) ro = pd;
      m_cnt = (m_cnt + 1) % TD;
      ml3 = ms2[2]; ms2 = ms1; mk2 = mk1;
      mk1 = bus.KEY; ms1 = {bus.SW[6], bus.SW[5], bus.SW[0]};
      m_row = nr; m_col = nc; m_st = nst; m_p1r = np1r; m_p1c = np1c; pd = npd;
    end
  endtask

  task automatic compare_all();
    check("cur_row", 32'(bus.cur_row), 32'(m_row));
    check("cur_col", 32'(bus.cur_col), 32'(m_col));
    check("roi_state", 32'(bus.roi_state), 32'(m_st));
    check("roi_min_row", 32'(bus.roi_min_row), 32'(ro[0]));
    check("roi_max_row", 32'(bus.roi_max_row), 32'(ro[1]));
    check("roi_min_col", 32'(bus.roi_min_col), 32'(ro[2]));
    check("roi_max_col", 32'(bus.roi_max_col), 32'(ro[3]));
    check("roi_valid", 32'(bus.roi_valid), 32'(ro[4]));
  endtask

  task automatic tick1();
    @(posedge CLOCK_50);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic cycles(input int n);
    repeat (n) tick1();
  endtask

  // n single-step moves, each a separate press so acceleration never engages
  task automatic move(input logic [3:0] mask, input int n);
    for (int i = 0; i < n; i++) begin
      int start = moves;
      int guard = 0;
      bus.KEY = ~mask;
      while (moves == start && guard < 50) begin tick1(); guard++; end
      assert (guard < 50) else begin n_fail++; $error("FAIL move_wait: observed %0d expected 1", moves - start); end
      bus.KEY = 4'hF;
      cycles(3);
    end
  endtask

  task automatic hold(input logic [3:0] mask, input int exp_col[4]);
    bus.KEY = ~mask;
    for (int i = 0; i < 4; i++) begin
      int start = moves;
      int guard = 0;
      while (moves == start && guard < 50) begin tick1(); guard++; end
      check("hold_col", 32'(bus.cur_col), 32'(exp_col[i]));
    end
    bus.KEY = 4'hF;
    cycles(3);
  endtask

  task automatic frame_pulse();
    bus.frame_start = 1'b1;
    tick1();
    bus.frame_start = 1'b0;
  endtask

  initial begin
    int exp6[4];
    moves = 0;
    model_reset();
    bus.KEY = 4'hF; bus.SW = '0; bus.frame_start = 1'b0;
    cycles(3);
    check("rst_row", 32'(bus.cur_row), 32'd240);
    check("rst_col", 32'(bus.cur_col), 32'd320);
    check("rst_state", 32'(bus.roi_state), 32'd0);
    check("rst_valid", 32'(bus.roi_valid), 32'd0);
    check("rst_max_col", 32'(bus.roi_max_col), 32'd0);
    reset = 1'b0;
    bus.SW[0] = 1'b1;
    cycles(3);

    move(4'b1000, 3);
    check("left3_col", 32'(bus.cur_col), 32'd296);
    check("left3_row", 32'(bus.cur_row), 32'd240);
    move(4'b1000, 37);
    check("col_zero", 32'(bus.cur_col), 32'd0);
    move(4'b1000, 1);
    check("wrap_left", 32'(bus.cur_col), 32'd632);
    move(4'b0001, 1);
    check("wrap_right", 32'(bus.cur_col), 32'd0);
    move(4'b0010, 29);
    check("row_472", 32'(bus.cur_row), 32'd472);
    move(4'b0010, 1);
    check("wrap_down", 32'(bus.cur_row), 32'd0);
    move(4'b0100, 1);
    check("wrap_up", 32'(bus.cur_row), 32'd472);
    move(4'b0100, 29);
    move(4'b0001, 40);
    check("home_row", 32'(bus.cur_row), 32'd240);
    check("home_col", 32'(bus.cur_col), 32'd320);

    bus.SW[5] = 1'b1; cycles(4);
    check("ready", 32'(bus.roi_state), 32'd1);
    bus.SW[6] = 1'b1; cycles(4);
    check("lock1", 32'(bus.roi_state), 32'd2);
    move(4'b0100, 5);
    move(4'b0001, 5);
    bus.SW[6] = 1'b0; cycles(4);
    check("lock2", 32'(bus.roi_state), 32'd3);
    check("no_commit_yet", 32'(bus.roi_valid), 32'd0);
    frame_pulse();
    check("c1_min_row", 32'(bus.roi_min_row), 32'd200);
    check("c1_max_row", 32'(bus.roi_max_row), 32'd240);
    check("c1_min_col", 32'(bus.roi_min_col), 32'd320);
    check("c1_max_col", 32'(bus.roi_max_col), 32'd360);
    check("c1_valid", 32'(bus.roi_valid), 32'd1);

    move(4'b0010, 5);
    move(4'b1000, 5);
    bus.SW[6] = 1'b1; cycles(4);
    bus.SW[6] = 1'b0; cycles(4);
    check("degen_state", 32'(bus.roi_state), 32'd3);
    check("degen_held", 32'(bus.roi_valid), 32'd1);
    frame_pulse();
    check("degen_valid", 32'(bus.roi_valid), 32'd0);
    check("degen_min_row", 32'(bus.roi_min_row), 32'd0);
    check("degen_max_col", 32'(bus.roi_max_col), 32'd0);
    move(4'b1010, 1);
    check("prio_col", 32'(bus.cur_col), 32'd312);
    check("prio_row", 32'(bus.cur_row), 32'd240);

    bus.SW[6] = 1'b1; cycles(4);
    move(4'b0100, 2);
    move(4'b0001, 2);
    bus.SW[6] = 1'b0; cycles(4);
    frame_pulse();
    check("c2_min_row", 32'(bus.roi_min_row), 32'd224);
    check("c2_max_col", 32'(bus.roi_max_col), 32'd328);
    check("c2_valid", 32'(bus.roi_valid), 32'd1);
    bus.SW[0] = 1'b0; cycles(4);
    check("off_state", 32'(bus.roi_state), 32'd0);
    check("off_row", 32'(bus.cur_row), 32'd240);
    check("off_col", 32'(bus.cur_col), 32'd320);
    check("off_valid_held", 32'(bus.roi_valid), 32'd1);
    frame_pulse();
    check("off_valid_clr", 32'(bus.roi_valid), 32'd0);
    check("off_min_col", 32'(bus.roi_min_col), 32'd0);
    bus.SW[6] = 1'b0; bus.SW[0] = 1'b1; cycles(4);
    bus.SW[6] = 1'b1; cycles(4);
    check("pre_rst_lock1", 32'(bus.roi_state), 32'd2);
    reset = 1'b1; tick1();
    check("mid_rst_state", 32'(bus.roi_state), 32'd0);
    check("mid_rst_row", 32'(bus.cur_row), 32'd240);
    check("mid_rst_col", 32'(bus.cur_col), 32'd320);
    reset = 1'b0; bus.SW = '0; cycles(2);
    reset = 1'b1; tick1(); reset = 1'b0;

    bus.SW[0] = 1'b1; cycles(3);
`ifdef CURSOR_ACCEL_EN
    exp6 = '{328, 336, 352, 368};
`else
    exp6 = '{328, 336, 344, 352};
`endif
    hold(4'b0001, exp6);

    bus.SW = 10'b0000100001;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) bus.KEY = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      if ($urandom_range(0, 39) == 0) bus.SW[6] = ~bus.SW[6];
      if ($urandom_range(0, 149) == 0) bus.SW[5] = ~bus.SW[5];
      if ($urandom_range(0, 299) == 0) bus.SW[0] = ~bus.SW[0];
      if ($urandom_range(0, 49) == 0) bus.SW[4:1] = 4'($urandom);
      bus.frame_start = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 999) == 0);
      tick1();
    end
    reset = 1'b0;
    bus.frame_start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
